// File: rtl/ni_packet_tx.sv
// Network-interface packet transmitter.
// Takes a packet request (destination column/row plus a payload length),
// then streams a HEADER flit, the payload words as BODY flits and a final
// TAIL flit into a switch virtual-channel FIFO. The FIFO's rdy_i signal is
// its "not full" indication. A zero-length packet is sent as HEADER followed
// by an empty TAIL. One output register decouples the FSM from the FIFO, so
// a flit is held stable while the FIFO is full.
module ni_packet_tx #(
  parameter int                   FLIT_DATA_W = 8,
  parameter int                   FLIT_ID_W   = 2,
  parameter int                   COL_ADDR_W  = 2,
  parameter int                   ROW_ADDR_W  = 2,
  parameter int                   PKT_LEN_W   = 4,
  parameter logic [FLIT_ID_W-1:0] HEADER_ID   = 2'b10,
  parameter logic [FLIT_ID_W-1:0] BODY_ID     = 2'b01,
  parameter logic [FLIT_ID_W-1:0] TAIL_ID     = 2'b11,
  localparam int                  FLIT_W      = FLIT_DATA_W + FLIT_ID_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   pkt_vld_i,
  output logic                   pkt_rdy_o,
  input  logic [COL_ADDR_W-1:0]  pkt_col_i,
  input  logic [ROW_ADDR_W-1:0]  pkt_row_i,
  input  logic [PKT_LEN_W-1:0]   pkt_len_i,
  input  logic [FLIT_DATA_W-1:0] pl_data_i,
  input  logic                   pl_vld_i,
  output logic                   pl_rdy_o,
  output logic [FLIT_W-1:0]      data_o,
  output logic                   wr_en_o,
  input  logic                   rdy_i,
  output logic                   busy_o,
  output logic [15:0]            pkt_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_PL    = 2'd2,
    ST_ZTAIL = 2'd3
  } state_e;

  state_e                 state_q;
  logic [COL_ADDR_W-1:0]  col_q;
  logic [ROW_ADDR_W-1:0]  row_q;
  logic [PKT_LEN_W-1:0]   rem_q;
  logic [FLIT_W-1:0]      flit_q;
  logic                   flit_vld_q;
  logic [15:0]            cnt_q;

  logic                   slot_free;
  logic                   tail_written;
  logic [FLIT_DATA_W-1:0] hdr_data;

  // The output register can take a new flit when it is empty or being drained this cycle.
  assign slot_free    = ~flit_vld_q | rdy_i;
  assign tail_written = flit_vld_q & rdy_i & (flit_q[FLIT_W-1 -: FLIT_ID_W] == TAIL_ID);

  // Build the header payload: row in the low bits, column above it, zero elsewhere.
  always_comb begin
    // NOTE: every bit gets a default before the partial overwrites, so no latch is inferred.
    hdr_data                             = '0;
    hdr_data[ROW_ADDR_W-1:0]             = row_q;
    hdr_data[ROW_ADDR_W +: COL_ADDR_W]   = col_q;
  end

  // Packet FSM, output flit register and tail counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: every register here is a plain flop (no memory array), so all of them are reset.
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      rem_q      <= '0;
      flit_q     <= '0;
      flit_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; the later flit load overrides this clear.
      if (slot_free) begin
        flit_vld_q <= 1'b0;
      end

      if (tail_written) begin
        cnt_q <= cnt_q + 16'd1;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (pkt_vld_i) begin
            col_q   <= pkt_col_i;
            row_q   <= pkt_row_i;
            rem_q   <= pkt_len_i;
            state_q <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (slot_free) begin
            flit_q     <= {HEADER_ID, hdr_data};
            flit_vld_q <= 1'b1;
            state_q    <= (rem_q != '0) ? ST_PL : ST_ZTAIL;
          end
        end

        ST_PL: begin
          if (pl_vld_i && slot_free) begin
            flit_q     <= {(rem_q > PKT_LEN_W'(1)) ? BODY_ID : TAIL_ID, pl_data_i};
            flit_vld_q <= 1'b1;
            rem_q      <= rem_q - PKT_LEN_W'(1);
            if (rem_q == PKT_LEN_W'(1)) begin
              state_q <= ST_IDLE;
            end
          end
        end

        ST_ZTAIL: begin
          if (slot_free) begin
            flit_q     <= {TAIL_ID, {FLIT_DATA_W{1'b0}}};
            flit_vld_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pkt_rdy_o = (state_q == ST_IDLE);
  assign pl_rdy_o  = (state_q == ST_PL) & slot_free;
  assign wr_en_o   = flit_vld_q & rdy_i;
  assign data_o    = flit_q;
  assign busy_o    = (state_q != ST_IDLE) | flit_vld_q;
  assign pkt_cnt_o = cnt_q;

endmodule

// File: tb/tb_ni_packet_tx.sv
// Testbench for ni_packet_tx. A stream driver offers packet requests and
// payload words cycle by cycle and records every FIFO write; each test
// compares that record against flit sequences derived directly from the
// packet format (header, body..., tail) or written out as constants.
module tb_ni_packet_tx;

  localparam logic [1:0] HEADER_ID = 2'b10;
  localparam logic [1:0] BODY_ID   = 2'b01;
  localparam logic [1:0] TAIL_ID   = 2'b11;

  typedef struct packed {
    logic [1:0] col;
    logic [1:0] row;
    logic [3:0] len;
  } pkt_t;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       pkt_vld_i = 1'b0;
  logic       pkt_rdy_o;
  logic [1:0] pkt_col_i = '0;
  logic [1:0] pkt_row_i = '0;
  logic [3:0] pkt_len_i = '0;
  logic [7:0] pl_data_i = '0;
  logic       pl_vld_i = 1'b0;
  logic       pl_rdy_o;
  logic [9:0] data_o;
  logic       wr_en_o;
  logic       rdy_i = 1'b1;
  logic       busy_o;
  logic [15:0] pkt_cnt_o;

  ni_packet_tx dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .pkt_vld_i (pkt_vld_i),
    .pkt_rdy_o (pkt_rdy_o),
    .pkt_col_i (pkt_col_i),
    .pkt_row_i (pkt_row_i),
    .pkt_len_i (pkt_len_i),
    .pl_data_i (pl_data_i),
    .pl_vld_i  (pl_vld_i),
    .pl_rdy_o  (pl_rdy_o),
    .data_o    (data_o),
    .wr_en_o   (wr_en_o),
    .rdy_i     (rdy_i),
    .busy_o    (busy_o),
    .pkt_cnt_o (pkt_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  // Stimulus description for one stream.
  pkt_t       pkts[$];
  logic [7:0] pl_all[$];
  int         rdy_mode;    // 0: always ready, 1: random
  int         vld_mode;    // 0: always valid, 1: 1010 pattern, 2: random
  int         stall_from;  // rdy_i forced low from accept+stall_from ...
  int         stall_n;     // ... for this many cycles (0 = no stall)

  // Observations from one stream.
  logic [9:0] obs_q[$];
  int         obs_cyc[$];
  int         acc_cyc[$];
  int         hs_cyc[$];
  logic [9:0] stall_data[$];
  int         stall_hs;
  int         stall_busy_bad;
  int         wr_without_rdy;
  bit         pl_rdy_seen;

  logic [9:0] exp_q[$];

  // Expected flit sequence straight from the packet format.
  function automatic void build_expected();
    int pi = 0;
    exp_q.delete();
    foreach (pkts[k]) begin
      exp_q.push_back({HEADER_ID, 4'b0000, pkts[k].col, pkts[k].row});
      if (pkts[k].len == 0) begin
        exp_q.push_back({TAIL_ID, 8'h00});
      end else begin
        for (int i = 0; i < int'(pkts[k].len); i++) begin
          exp_q.push_back({(i == int'(pkts[k].len) - 1) ? TAIL_ID : BODY_ID, pl_all[pi]});
          pi++;
        end
      end
    end
  endfunction

  // Index of the first difference between observed and expected streams, -1 if identical.
  function automatic int stream_diff();
    int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (obs_q[i] !== exp_q[i]) return i;
    end
    if (obs_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [9:0] obs_at(input int i);
    return (i < obs_q.size()) ? obs_q[i] : 10'h3FF;
  endfunction

  function automatic logic [9:0] exp_at(input int i);
    return (i < exp_q.size()) ? exp_q[i] : 10'h3FF;
  endfunction

  // Drive the packet list and payload stream; record writes until every tail is seen.
  task automatic run_stream(input int max_cyc, output bit timed_out);
    int p = 0;
    int pi = 0;
    int tails = 0;
    bit v;
    bit r;
    bit in_stall;
    obs_q.delete(); obs_cyc.delete(); acc_cyc.delete(); hs_cyc.delete(); stall_data.delete();
    stall_hs = 0; stall_busy_bad = 0; wr_without_rdy = 0; pl_rdy_seen = 0;
    timed_out = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      if (p < pkts.size()) begin
        pkt_vld_i = 1'b1;
        pkt_col_i = pkts[p].col;
        pkt_row_i = pkts[p].row;
        pkt_len_i = pkts[p].len;
      end else begin
        pkt_vld_i = 1'b0;
        pkt_col_i = 2'($urandom);
        pkt_row_i = 2'($urandom);
        pkt_len_i = 4'($urandom);
      end
      case (vld_mode)
        0:       v = 1'b1;
        1:       v = (c % 2 == 0);
        default: v = ($urandom_range(0, 9) < 7);
      endcase
      pl_vld_i  = v && (pi < pl_all.size());
      pl_data_i = pl_vld_i ? pl_all[pi] : 8'($urandom);
      r = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      in_stall = (stall_n > 0) && (acc_cyc.size() > 0) &&
                 (c >= acc_cyc[0] + stall_from) && (c < acc_cyc[0] + stall_from + stall_n);
      if (in_stall) r = 1'b0;
      rdy_i = r;

      @(negedge clk_i);
      if (pl_rdy_o) pl_rdy_seen = 1'b1;
      if (wr_en_o && !rdy_i) wr_without_rdy++;
      if (in_stall) begin
        stall_data.push_back(wr_en_o ? 10'h3FF : data_o);
        if (!busy_o) stall_busy_bad++;
        if (pl_vld_i && pl_rdy_o) stall_hs++;
      end
      if (pkt_vld_i && pkt_rdy_o) begin
        acc_cyc.push_back(c);
        p++;
      end
      if (pl_vld_i && pl_rdy_o) begin
        hs_cyc.push_back(c);
        pi++;
      end
      if (wr_en_o) begin
        obs_q.push_back(data_o);
        obs_cyc.push_back(c);
        if (data_o[9:8] == TAIL_ID) tails++;
      end
      @(posedge clk_i);
      #1;
      if (p >= pkts.size() && tails >= pkts.size()) begin
        timed_out = 1'b0;
        break;
      end
    end
    pkt_vld_i = 1'b0;
    pl_vld_i  = 1'b0;
    rdy_i     = 1'b1;
  endtask

  task automatic set_modes(input int rm, input int vm, input int sf, input int sn);
    rdy_mode = rm; vld_mode = vm; stall_from = sf; stall_n = sn;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({pkt_rdy_o, pl_rdy_o, wr_en_o, busy_o} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: got rdy/plrdy/wr/busy=%b, want 1000",
               {pkt_rdy_o, pl_rdy_o, wr_en_o, busy_o});
    end
    checks++;
    if (data_o !== 10'h000 || pkt_cnt_o !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got data=%h cnt=%h, want 000/0000", data_o, pkt_cnt_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_basic();
    bit to;
    int d;
    pkts.delete(); pl_all.delete();
    pkts.push_back('{col: 2'd1, row: 2'd2, len: 4'd3});
    pl_all.push_back(8'hA1); pl_all.push_back(8'hA2); pl_all.push_back(8'hA3);
    set_modes(0, 0, 0, 0);
    run_stream(100, to);
    exp_q = '{10'h206, 10'h1A1, 10'h1A2, 10'h3A3};
    d = stream_diff();
    checks++;
    if (to || d != -1) begin
      errors++;
      $display("FAIL basic_stream: timeout=%0d idx=%0d got %h want %h", to, d, obs_at(d), exp_at(d));
    end
    checks++;
    if (obs_cyc.size() != 4 || acc_cyc.size() != 1 ||
        obs_cyc[0] != acc_cyc[0] + 2 || obs_cyc[3] != obs_cyc[0] + 3) begin
      errors++;
      $display("FAIL basic_timing: header write cycle/last cycle not accept+2 and 4 consecutive (writes=%0d)",
               obs_cyc.size());
    end
    exp_cnt += 1;
    checks++;
    if (pkt_cnt_o !== 16'(exp_cnt) || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_cnt_busy: got cnt=%0d busy=%b, want %0d/0", pkt_cnt_o, busy_o, exp_cnt);
    end
  endtask

  task automatic test_zero_len();
    bit to;
    int d;
    pkts.delete(); pl_all.delete();
    pkts.push_back('{col: 2'd3, row: 2'd0, len: 4'd0});
    set_modes(0, 0, 0, 0);
    run_stream(100, to);
    exp_q = '{10'h20C, 10'h300};
    d = stream_diff();
    checks++;
    if (to || d != -1) begin
      errors++;
      $display("FAIL zero_len_stream: timeout=%0d idx=%0d got %h want %h", to, d, obs_at(d), exp_at(d));
    end
    checks++;
    if (pl_rdy_seen !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_plrdy: pl_rdy_o pulsed=%b, want 0", pl_rdy_seen);
    end
    exp_cnt += 1;
    checks++;
    if (pkt_cnt_o !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL zero_len_cnt: got %0d want %0d", pkt_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_stall();
    bit to;
    int d;
    int bad = 0;
    logic [9:0] hdr;
    pkts.delete(); pl_all.delete();
    pkts.push_back('{col: 2'($urandom), row: 2'($urandom), len: 4'd4});
    for (int i = 0; i < 4; i++) pl_all.push_back(8'($urandom));
    hdr = {HEADER_ID, 4'b0000, pkts[0].col, pkts[0].row};
    // Header sits in the output register from accept+2; hold the FIFO full for 5 cycles there.
    set_modes(0, 0, 2, 5);
    run_stream(100, to);
    build_expected();
    d = stream_diff();
    checks++;
    if (to || d != -1) begin
      errors++;
      $display("FAIL stall_stream: timeout=%0d idx=%0d got %h want %h", to, d, obs_at(d), exp_at(d));
    end
    foreach (stall_data[i]) if (stall_data[i] !== hdr) bad++;
    checks++;
    if (stall_data.size() != 5 || bad != 0) begin
      errors++;
      $display("FAIL stall_hold: cycles=%0d bad=%0d, want 5 cycles holding %h unwritten",
               stall_data.size(), bad, hdr);
    end
    checks++;
    if (stall_hs != 0 || stall_busy_bad != 0 || wr_without_rdy != 0) begin
      errors++;
      $display("FAIL stall_protocol: payload_taken=%0d not_busy=%0d wr_without_rdy=%0d, want 0/0/0",
               stall_hs, stall_busy_bad, wr_without_rdy);
    end
    exp_cnt += 1;
    checks++;
    if (pkt_cnt_o !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL stall_cnt: got %0d want %0d", pkt_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int d;
    pkts.delete(); pl_all.delete();
    pkts.push_back('{col: 2'd2, row: 2'd1, len: 4'd2});
    pkts.push_back('{col: 2'd0, row: 2'd3, len: 4'd1});
    pl_all.push_back(8'h5A); pl_all.push_back(8'hC3); pl_all.push_back(8'h7E);
    set_modes(0, 0, 0, 0);
    run_stream(100, to);
    build_expected();
    d = stream_diff();
    checks++;
    if (to || d != -1) begin
      errors++;
      $display("FAIL b2b_stream: timeout=%0d idx=%0d got %h want %h", to, d, obs_at(d), exp_at(d));
    end
    // Tail leaves at T; the next request is accepted in IDLE at T and its header goes out by T+2.
    checks++;
    if (obs_cyc.size() != 5 || obs_cyc[3] - obs_cyc[2] > 2 || obs_cyc[3] <= obs_cyc[2]) begin
      errors++;
      $display("FAIL b2b_gap: second header not written within 2 cycles of first tail (writes=%0d)",
               obs_cyc.size());
    end
    exp_cnt += 2;
    checks++;
    if (pkt_cnt_o !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL b2b_cnt: got %0d want %0d", pkt_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_packet();
    bit to;
    int d;
    pkts.delete(); pl_all.delete();
    pkts.push_back('{col: 2'd1, row: 2'd1, len: 4'd5});
    for (int i = 0; i < 5; i++) pl_all.push_back(8'($urandom));
    set_modes(0, 0, 0, 0);
    // Four cycles: accept, header load, header write, first body write.
    run_stream(4, to);
    checks++;
    if (!to || obs_q.size() < 2 || obs_q[0][9:8] !== HEADER_ID || obs_q[obs_q.size()-1][9:8] !== BODY_ID) begin
      errors++;
      $display("FAIL rst_mid_setup: writes=%0d, want header then body in progress", obs_q.size());
    end
    pl_vld_i = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({pl_rdy_o, wr_en_o, busy_o} !== 3'b000 || data_o !== 10'h000 || pkt_cnt_o !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid_async: got plrdy/wr/busy=%b data=%h cnt=%h, want 000/000/0000",
               {pl_rdy_o, wr_en_o, busy_o}, data_o, pkt_cnt_o);
    end
    pl_vld_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    exp_cnt = 0;
    pkts.delete(); pl_all.delete();
    pkts.push_back('{col: 2'd2, row: 2'd3, len: 4'd2});
    pl_all.push_back(8'h11); pl_all.push_back(8'h22);
    run_stream(100, to);
    build_expected();
    d = stream_diff();
    checks++;
    if (to || d != -1) begin
      errors++;
      $display("FAIL rst_mid_restart: timeout=%0d idx=%0d got %h want %h", to, d, obs_at(d), exp_at(d));
    end
    exp_cnt += 1;
    checks++;
    if (pkt_cnt_o !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL rst_mid_cnt: got %0d want %0d", pkt_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_payload_bubbles();
    bit to;
    int d;
    int bad = 0;
    pkts.delete(); pl_all.delete();
    pkts.push_back('{col: 2'd3, row: 2'd2, len: 4'd4});
    for (int i = 0; i < 4; i++) pl_all.push_back(8'($urandom));
    set_modes(0, 1, 0, 0);
    run_stream(100, to);
    build_expected();
    d = stream_diff();
    checks++;
    if (to || d != -1) begin
      errors++;
      $display("FAIL bubbles_stream: timeout=%0d idx=%0d got %h want %h", to, d, obs_at(d), exp_at(d));
    end
    // Each body/tail write must follow a valid (even) payload cycle by exactly one clock.
    if (hs_cyc.size() != 4 || obs_cyc.size() != 5) bad++;
    else foreach (hs_cyc[i]) if (hs_cyc[i] % 2 != 0 || obs_cyc[i+1] != hs_cyc[i] + 1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bubbles_timing: %0d payload writes off valid cycles, want 0", bad);
    end
    exp_cnt += 1;
    checks++;
    if (pkt_cnt_o !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL bubbles_cnt: got %0d want %0d", pkt_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_random();
    bit to;
    int d;
    for (int round = 0; round < 4; round++) begin
      pkts.delete(); pl_all.delete();
      for (int k = 0; k < 5; k++) begin
        pkt_t pk;
        pk.col = 2'($urandom);
        pk.row = 2'($urandom);
        pk.len = (k == 0) ? 4'd15 : 4'($urandom);
        pkts.push_back(pk);
        for (int i = 0; i < int'(pk.len); i++) pl_all.push_back(8'($urandom));
      end
      set_modes(1, 2, 0, 0);
      run_stream(3000, to);
      build_expected();
      d = stream_diff();
      checks++;
      if (to || d != -1) begin
        errors++;
        $display("FAIL random_stream[%0d]: timeout=%0d idx=%0d got %h want %h",
                 round, to, d, obs_at(d), exp_at(d));
      end
      exp_cnt += 5;
      checks++;
      if (pkt_cnt_o !== 16'(exp_cnt) || wr_without_rdy != 0) begin
        errors++;
        $display("FAIL random_cnt[%0d]: got cnt=%0d wr_without_rdy=%0d, want %0d/0",
                 round, pkt_cnt_o, wr_without_rdy, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_stall();
    test_back_to_back();
    test_reset_mid_packet();
    test_payload_bubbles();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
